// File: rtl/button_event_ctrl.sv
// Debounce controller and event scheduler for N push-buttons. Press, release and long-press
// events are arbitrated round-robin into a small FIFO with a valid/ready output.
module button_event_ctrl #(
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned TICK_DIV   = 250000,
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned LONG_CNT   = 400,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         btn_n,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic [1:0]               evt_type,
    output logic [N_BTN-1:0]         btn_state,
    output logic                     overflow
);
    localparam int unsigned ID_W   = $clog2(N_BTN);
    localparam int unsigned SUM_W  = ID_W + 1;
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned STAB_W = $clog2(STABLE_CNT);
    localparam int unsigned HOLD_W = $clog2(LONG_CNT + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [1:0] TYPE_PRESS   = 2'b01;
    localparam logic [1:0] TYPE_RELEASE = 2'b10;
    localparam logic [1:0] TYPE_LONG    = 2'b11;

    logic [N_BTN-1:0]  sync1, sync2, raw_c;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick_c;

    logic [STAB_W-1:0] stab_cnt   [N_BTN];
    logic [STAB_W-1:0] stab_nxt_c [N_BTN];
    logic [HOLD_W-1:0] hold_cnt   [N_BTN];
    logic [HOLD_W-1:0] hold_nxt_c [N_BTN];
    logic [N_BTN-1:0]  state_nxt_c, press_evt_c, rel_evt_c, long_evt_c;
    logic [N_BTN-1:0]  press_pend, rel_pend, long_pend;
    logic [N_BTN-1:0]  press_clr_c, rel_clr_c, long_clr_c;
    logic [N_BTN-1:0]  press_keep_c, rel_keep_c, long_keep_c;
    logic [N_BTN-1:0]  press_nxt_c, rel_nxt_c, long_nxt_c;
    logic              ovf_hit_c;

    logic [ID_W-1:0]   rr_ptr, rr_nxt_c, gnt_id_c, sel_c;
    logic [SUM_W-1:0]  sum_c;
    logic [1:0]        gnt_type_c;
    logic              grant_c, fifo_room_c;

    logic [ID_W-1:0]   mem_id   [FIFO_DEPTH];
    logic [1:0]        mem_type [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_nxt_c;
    logic [CNT_W-1:0]  fifo_cnt, cnt_nxt_c;
    logic              pop_c;
    logic [ID_W-1:0]   head_id_c;
    logic [1:0]        head_type_c;

    // Two-flop synchroniser; idle (released) level is 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    assign raw_c  = ~sync2;
    assign tick_c = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick_c) tick_cnt <= '0;
        else               tick_cnt <= tick_cnt + TICK_W'(1);
    end

    // Per-button debounce and long-press hold counting.
    always_comb begin
        state_nxt_c = btn_state;
        press_evt_c = '0;
        rel_evt_c   = '0;
        long_evt_c  = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            stab_nxt_c[i] = stab_cnt[i];
            hold_nxt_c[i] = hold_cnt[i];
            if (tick_c) begin
                if (raw_c[i] == btn_state[i]) begin
                    stab_nxt_c[i] = '0;
                end else if (stab_cnt[i] == STAB_W'(STABLE_CNT - 1)) begin
                    stab_nxt_c[i]  = '0;
                    state_nxt_c[i] = raw_c[i];
                    press_evt_c[i] = raw_c[i];
                    rel_evt_c[i]   = ~raw_c[i];
                end else begin
                    stab_nxt_c[i] = stab_cnt[i] + STAB_W'(1);
                end
                if (btn_state[i] && (hold_cnt[i] < HOLD_W'(LONG_CNT))) begin
                    hold_nxt_c[i] = hold_cnt[i] + HOLD_W'(1);
                    long_evt_c[i] = (hold_cnt[i] == HOLD_W'(LONG_CNT - 1));
                end
            end
            if (!btn_state[i]) hold_nxt_c[i] = '0;
        end
    end

    // A grant frees its flag before a same-cycle new event is checked for collision.
    always_comb begin
        press_keep_c = press_pend & ~press_clr_c;
        rel_keep_c   = rel_pend & ~rel_clr_c;
        long_keep_c  = long_pend & ~long_clr_c;
        press_nxt_c  = press_keep_c | press_evt_c;
        rel_nxt_c    = rel_keep_c | rel_evt_c;
        long_nxt_c   = long_keep_c | long_evt_c;
        ovf_hit_c    = |((press_keep_c & press_evt_c) | (rel_keep_c & rel_evt_c) |
                         (long_keep_c & long_evt_c));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                stab_cnt[i] <= '0;
                hold_cnt[i] <= '0;
            end
            btn_state  <= '0;
            press_pend <= '0;
            rel_pend   <= '0;
            long_pend  <= '0;
            overflow   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                stab_cnt[i] <= stab_nxt_c[i];
                hold_cnt[i] <= hold_nxt_c[i];
            end
            btn_state  <= state_nxt_c;
            press_pend <= press_nxt_c;
            rel_pend   <= rel_nxt_c;
            long_pend  <= long_nxt_c;
            overflow   <= overflow | ovf_hit_c;
        end
    end

    assign fifo_room_c = (fifo_cnt < CNT_W'(FIFO_DEPTH));

    // Round-robin search from rr_ptr; within a button: press, long, release.
    always_comb begin
        grant_c     = 1'b0;
        gnt_id_c    = '0;
        gnt_type_c  = '0;
        press_clr_c = '0;
        long_clr_c  = '0;
        rel_clr_c   = '0;
        sum_c       = '0;
        sel_c       = '0;
        for (int unsigned k = 0; k < N_BTN; k++) begin
            sum_c = {1'b0, rr_ptr} + SUM_W'(k);
            if (sum_c >= SUM_W'(N_BTN)) sum_c = sum_c - SUM_W'(N_BTN);
            sel_c = sum_c[ID_W-1:0];
            if (!grant_c && fifo_room_c &&
                (press_pend[sel_c] || long_pend[sel_c] || rel_pend[sel_c])) begin
                grant_c  = 1'b1;
                gnt_id_c = sel_c;
                if (press_pend[sel_c]) begin
                    gnt_type_c         = TYPE_PRESS;
                    press_clr_c[sel_c] = 1'b1;
                end else if (long_pend[sel_c]) begin
                    gnt_type_c        = TYPE_LONG;
                    long_clr_c[sel_c] = 1'b1;
                end else begin
                    gnt_type_c       = TYPE_RELEASE;
                    rel_clr_c[sel_c] = 1'b1;
                end
            end
        end
        rr_nxt_c = rr_ptr;
        if (grant_c) begin
            rr_nxt_c = (gnt_id_c == ID_W'(N_BTN - 1)) ? '0 : gnt_id_c + ID_W'(1);
        end
    end

    assign pop_c = evt_valid & evt_ready;

    // Next head is looked up ahead of time so the output fields are plain flops.
    always_comb begin
        rd_nxt_c  = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;
        cnt_nxt_c = fifo_cnt;
        if (grant_c && !pop_c)      cnt_nxt_c = fifo_cnt + CNT_W'(1);
        else if (!grant_c && pop_c) cnt_nxt_c = fifo_cnt - CNT_W'(1);
        if (grant_c && (wr_ptr == rd_nxt_c)) begin
            head_id_c   = gnt_id_c;
            head_type_c = gnt_type_c;
        end else begin
            head_id_c   = mem_id[rd_nxt_c];
            head_type_c = mem_type[rd_nxt_c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
                mem_id[j]   <= '0;
                mem_type[j] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            rr_ptr    <= '0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_type  <= '0;
        end else begin
            if (grant_c) begin
                mem_id[wr_ptr]   <= gnt_id_c;
                mem_type[wr_ptr] <= gnt_type_c;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            rd_ptr    <= rd_nxt_c;
            fifo_cnt  <= cnt_nxt_c;
            rr_ptr    <= rr_nxt_c;
            evt_valid <= (cnt_nxt_c != '0);
            evt_id    <= head_id_c;
            evt_type  <= head_type_c;
        end
    end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: directed scenarios plus random button/ready activity, all
// checked every cycle against an array/queue reference model of the event rules.
module tb_button_event_ctrl;
    localparam int NB = 4;
    localparam int TD = 4;
    localparam int SC = 3;
    localparam int LC = 5;
    localparam int FD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_n;
    logic          evt_valid;
    logic          evt_ready;
    logic [1:0]    evt_id;
    logic [1:0]    evt_type;
    logic [NB-1:0] btn_state;
    logic          overflow;

    always #5 clk = ~clk;

    button_event_ctrl #(
        .N_BTN(NB), .TICK_DIV(TD), .STABLE_CNT(SC), .LONG_CNT(LC), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .btn_n(btn_n), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_id(evt_id), .evt_type(evt_type), .btn_state(btn_state), .overflow(overflow)
    );

    int checks = 0;
    int errors = 0;
    int log_q[$];

    // Reference model: events are encoded id*4 + type.
    int m_s1[NB], m_s2[NB], m_stab[NB], m_state[NB], m_hold[NB];
    bit m_pp[NB], m_lp[NB], m_rp[NB];
    int m_tc, m_rr;
    bit m_ovf;
    int m_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void post_evt(input int b, input int kind);
        case (kind)
            1:       if (m_pp[b]) m_ovf = 1'b1; else m_pp[b] = 1'b1;
            3:       if (m_lp[b]) m_ovf = 1'b1; else m_lp[b] = 1'b1;
            default: if (m_rp[b]) m_ovf = 1'b1; else m_rp[b] = 1'b1;
        endcase
    endfunction

    function automatic logic [NB-1:0] model_state_vec();
        logic [NB-1:0] v;
        for (int i = 0; i < NB; i++) v[i] = (m_state[i] != 0);
        return v;
    endfunction

    task automatic model_step();
        int  g;
        int  ty;
        int  b;
        int  raw;
        int  prev[NB];
        bit  tick;
        if (rst) begin
            for (int i = 0; i < NB; i++) begin
                m_s1[i] = 1; m_s2[i] = 1; m_stab[i] = 0; m_state[i] = 0; m_hold[i] = 0;
                m_pp[i] = 0; m_lp[i] = 0; m_rp[i] = 0;
            end
            m_tc = 0; m_rr = 0; m_ovf = 0;
            m_q.delete();
            return;
        end
        tick = (m_tc == TD - 1);
        g = -1;
        if (m_q.size() < FD) begin
            for (int k = 0; k < NB; k++) begin
                b = (m_rr + k) % NB;
                if (g < 0 && (m_pp[b] || m_lp[b] || m_rp[b])) g = b;
            end
        end
        if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
        if (g >= 0) begin
            if (m_pp[g])      begin ty = 1; m_pp[g] = 0; end
            else if (m_lp[g]) begin ty = 3; m_lp[g] = 0; end
            else              begin ty = 2; m_rp[g] = 0; end
            m_q.push_back(g * 4 + ty);
            m_rr = (g + 1) % NB;
        end
        for (int i = 0; i < NB; i++) prev[i] = m_state[i];
        for (int i = 0; i < NB; i++) begin
            if (tick) begin
                raw = 1 - m_s2[i];
                if (raw == prev[i]) m_stab[i] = 0;
                else if (m_stab[i] == SC - 1) begin
                    m_state[i] = raw;
                    m_stab[i]  = 0;
                    post_evt(i, raw ? 1 : 2);
                end else m_stab[i]++;
                if (prev[i] == 1 && m_hold[i] < LC) begin
                    m_hold[i]++;
                    if (m_hold[i] == LC) post_evt(i, 3);
                end
            end
            if (prev[i] == 0) m_hold[i] = 0;
            m_s2[i] = m_s1[i];
            m_s1[i] = int'(btn_n[i]);
        end
        m_tc = (m_tc + 1) % TD;
    endtask

    task automatic cycle();
        if (evt_valid === 1'b1 && evt_ready === 1'b1)
            log_q.push_back(int'(evt_id) * 4 + int'(evt_type));
        @(posedge clk);
        model_step();
        #1;
        check_eq("evt_valid", evt_valid, int'(m_q.size() != 0));
        check_eq("btn_state", btn_state, int'(model_state_vec()));
        check_eq("overflow", overflow, int'(m_ovf));
        if (m_q.size() != 0) begin
            check_eq("evt_id", evt_id, m_q[0] / 4);
            check_eq("evt_type", evt_type, m_q[0] % 4);
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run(2);
        rst = 1'b0;
    endtask

    task automatic wait_log(input int n, input int max_cyc, input string tag);
        int c = 0;
        while (log_q.size() < n && c < max_cyc) begin
            cycle();
            c++;
        end
        check_eq(tag, int'(log_q.size() >= n), 1);
    endtask

    function automatic int log_at(input int i);
        return (i < log_q.size()) ? log_q[i] : -1;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        btn_n = '1;
        evt_ready = 1'b0;
        run(2);
        check_eq("rst_evt_id", evt_id, 0);
        check_eq("rst_evt_type", evt_type, 0);
        rst = 1'b0;
        run(100);

        // Bouncing input never holds long enough, then a clean press.
        evt_ready = 1'b1;
        log_q.delete();
        for (int k = 0; k < 8; k++) begin
            btn_n[2] = ~btn_n[2];
            run(3);
        end
        check_eq("bounce_no_evt", log_q.size(), 0);
        btn_n[2] = 1'b0;
        run(20);
        check_eq("bounce_evt_cnt", log_q.size(), 1);
        check_eq("bounce_evt", log_at(0), 2 * 4 + 1);
        run(40);
        btn_n[2] = 1'b1;
        run(40);

        // Long hold: press, one long-press, release.
        log_q.delete();
        btn_n[1] = 1'b0;
        run(48);
        btn_n[1] = 1'b1;
        run(40);
        check_eq("long_cnt", log_q.size(), 3);
        check_eq("long_e0", log_at(0), 1 * 4 + 1);
        check_eq("long_e1", log_at(1), 1 * 4 + 3);
        check_eq("long_e2", log_at(2), 1 * 4 + 2);

        // Simultaneous press/release on buttons 0 and 3.
        do_reset();
        log_q.delete();
        btn_n = 4'b0110;
        wait_log(2, 40, "rr_press_timeout");
        btn_n = 4'b1111;
        wait_log(4, 40, "rr_rel_timeout");
        run(10);
        check_eq("rr_cnt", log_q.size(), 4);
        check_eq("rr_e0", log_at(0), 0 * 4 + 1);
        check_eq("rr_e1", log_at(1), 3 * 4 + 1);
        check_eq("rr_e2", log_at(2), 0 * 4 + 2);
        check_eq("rr_e3", log_at(3), 3 * 4 + 2);

        // Backpressure: FIFO fills, pending collision, then ordered drain.
        do_reset();
        evt_ready = 1'b0;
        btn_n = 4'b0000;
        run(15);
        btn_n = 4'b1111;
        run(15);
        btn_n[2] = 1'b0;
        run(16);
        check_eq("bp_overflow", overflow, 1);
        btn_n[2] = 1'b1;
        run(20);
        check_eq("bp_valid", evt_valid, 1);
        check_eq("bp_head_id", evt_id, 0);
        check_eq("bp_head_type", evt_type, 1);
        log_q.delete();
        evt_ready = 1'b1;
        wait_log(8, 60, "bp_drain_timeout");
        run(10);
        check_eq("bp_cnt", log_q.size(), 8);
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_press", log_at(i), i * 4 + 1);
            check_eq("bp_rel", log_at(i + 4), i * 4 + 2);
        end
        check_eq("bp_overflow_sticky", overflow, 1);

        // Reset while a button is held and an event is queued.
        evt_ready = 1'b0;
        btn_n[2] = 1'b0;
        run(20);
        check_eq("hr_valid_before", evt_valid, 1);
        rst = 1'b1;
        run(1);
        check_eq("hr_valid_after", evt_valid, 0);
        check_eq("hr_state_after", btn_state, 0);
        check_eq("hr_ovf_after", overflow, 0);
        rst = 1'b0;
        evt_ready = 1'b1;
        log_q.delete();
        wait_log(1, 40, "hr_reissue_timeout");
        check_eq("hr_reissue", log_at(0), 2 * 4 + 1);
        btn_n[2] = 1'b1;
        run(40);

        // Random activity against the model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            int b;
            if ($urandom_range(0, 15) == 0) begin
                b = int'($urandom_range(0, NB - 1));
                btn_n[b] = ~btn_n[b];
            end
            if ($urandom_range(0, 31) == 0) evt_ready = ~evt_ready;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
